radix4_bfly_pipe: RTL and testbench

- Pipelined, parametrised radix-4 DIT butterfly for the 16-point FFT datapath.
- Accepts four complex samples A..D and three runtime twiddles for B, C and D. W0 = 1 is implicit, so A is not multiplied.
- Produces the four radix-4 outputs after optional per-vector scaling.
- valid/ready handshake on both sides; sits between the sample-reorder buffer and the stage memory.

---
 rtl/radix4_bfly_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_radix4_bfly_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_bfly_pipe.sv
// Radix-4 DIT butterfly, 3-stage pipe:
// S1 twiddle multiply, S2 add, S3 scale/saturate.
module radix4_bfly_pipe #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    ar,
  input  logic signed [WIDTH-1:0]    ai,
  input  logic signed [WIDTH-1:0]    br,
  input  logic signed [WIDTH-1:0]    bi,
  input  logic signed [WIDTH-1:0]    cr,
  input  logic signed [WIDTH-1:0]    ci,
  input  logic signed [WIDTH-1:0]    dr,
  input  logic signed [WIDTH-1:0]    di,
  input  logic signed [TW_WIDTH-1:0] w1r,
  input  logic signed [TW_WIDTH-1:0] w1i,
  input  logic signed [TW_WIDTH-1:0] w2r,
  input  logic signed [TW_WIDTH-1:0] w2i,
  input  logic signed [TW_WIDTH-1:0] w3r,
  input  logic signed [TW_WIDTH-1:0] w3i,
  input  logic [1:0]                 shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    y0r,
  output logic signed [WIDTH-1:0]    y0i,
  output logic signed [WIDTH-1:0]    y1r,
  output logic signed [WIDTH-1:0]    y1i,
  output logic signed [WIDTH-1:0]    y2r,
  output logic signed [WIDTH-1:0]    y2i,
  output logic signed [WIDTH-1:0]    y3r,
  output logic signed [WIDTH-1:0]    y3i,
  output logic                       out_sat
);

  localparam int PW  = WIDTH + TW_WIDTH + 1;
  localparam int S2W = WIDTH + 2;
  localparam int S3W = WIDTH + 3;

  localparam logic signed [PW-1:0] TW_RND =
    PW'(1) <<< (TW_WIDTH - 2);
  localparam logic signed [PW-1:0] TW_MAX =
    PW'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] TW_MIN =
    PW'(-(1 <<< (WIDTH - 1)));
  localparam logic signed [S3W-1:0] S3_MAX =
    S3W'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [S3W-1:0] S3_MIN =
    S3W'(-(1 <<< (WIDTH - 1)));
  localparam logic signed [S3W-1:0] S3_ONE = S3W'(1);
  localparam logic signed [S3W-1:0] S3_TWO = S3W'(2);

  typedef struct packed {
    logic                    v;
    logic [1:0]              sh;
    logic                    sat;
    logic signed [WIDTH-1:0] ar;
    logic signed [WIDTH-1:0] ai;
    logic signed [WIDTH-1:0] br;
    logic signed [WIDTH-1:0] bi;
    logic signed [WIDTH-1:0] cr;
    logic signed [WIDTH-1:0] ci;
    logic signed [WIDTH-1:0] dr;
    logic signed [WIDTH-1:0] di;
  } s1_t;

  typedef struct packed {
    logic                  v;
    logic [1:0]            sh;
    logic                  sat;
    logic signed [S2W-1:0] y0r;
    logic signed [S2W-1:0] y0i;
    logic signed [S2W-1:0] y1r;
    logic signed [S2W-1:0] y1i;
    logic signed [S2W-1:0] y2r;
    logic signed [S2W-1:0] y2i;
    logic signed [S2W-1:0] y3r;
    logic signed [S2W-1:0] y3i;
  } s2_t;

  function automatic logic signed [PW-1:0] cre(
    input logic signed [WIDTH-1:0]    xr,
    input logic signed [WIDTH-1:0]    xi,
    input logic signed [TW_WIDTH-1:0] wr,
    input logic signed [TW_WIDTH-1:0] wi
  );
    return PW'(xr) * PW'(wr) - PW'(xi) * PW'(wi);
  endfunction

  function automatic logic signed [PW-1:0] cim(
    input logic signed [WIDTH-1:0]    xr,
    input logic signed [WIDTH-1:0]    xi,
    input logic signed [TW_WIDTH-1:0] wr,
    input logic signed [TW_WIDTH-1:0] wi
  );
    return PW'(xr) * PW'(wi) + PW'(xi) * PW'(wr);
  endfunction

  // {sat, value}: round Q1 product back to data scale
  function automatic logic [WIDTH:0] tw_q(
    input logic signed [PW-1:0] p
  );
    logic signed [PW-1:0] r;
    r = (p + TW_RND) >>> (TW_WIDTH - 1);
    if (r > TW_MAX)
      return {1'b1, TW_MAX[WIDTH-1:0]};
    else if (r < TW_MIN)
      return {1'b1, TW_MIN[WIDTH-1:0]};
    else
      return {1'b0, r[WIDTH-1:0]};
  endfunction

  // {sat, value}: rounded right shift by 0..2
  function automatic logic [WIDTH:0] sc_q(
    input logic signed [S2W-1:0] y,
    input logic [1:0]            s
  );
    logic signed [S3W-1:0] t;
    t = S3W'(y);
    case (s)
      2'd1:       t = (t + S3_ONE) >>> 1;
      2'd2, 2'd3: t = (t + S3_TWO) >>> 2;
      default:    t = t;
    endcase
    if (t > S3_MAX)
      return {1'b1, S3_MAX[WIDTH-1:0]};
    else if (t < S3_MIN)
      return {1'b1, S3_MIN[WIDTH-1:0]};
    else
      return {1'b0, t[WIDTH-1:0]};
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [WIDTH:0] qbr, qbi, qcr, qci, qdr, qdi;
  assign qbr = tw_q(cre(br, bi, w1r, w1i));
  assign qbi = tw_q(cim(br, bi, w1r, w1i));
  assign qcr = tw_q(cre(cr, ci, w2r, w2i));
  assign qci = tw_q(cim(cr, ci, w2r, w2i));
  assign qdr = tw_q(cre(dr, di, w3r, w3i));
  assign qdi = tw_q(cim(dr, di, w3r, w3i));

  s1_t s1_d, s1;
  s2_t s2_d, s2;

  // S1 next value: rotated B/C/D, A delayed, shift clamped
  always_comb begin
    s1_d     = '0;
    s1_d.v   = in_valid;
    s1_d.sh  = (shift == 2'd3) ? 2'd2 : shift;
    s1_d.sat = in_valid & (qbr[WIDTH] | qbi[WIDTH] |
                           qcr[WIDTH] | qci[WIDTH] |
                           qdr[WIDTH] | qdi[WIDTH]);
    s1_d.ar  = ar;
    s1_d.ai  = ai;
    s1_d.br  = qbr[WIDTH-1:0];
    s1_d.bi  = qbi[WIDTH-1:0];
    s1_d.cr  = qcr[WIDTH-1:0];
    s1_d.ci  = qci[WIDTH-1:0];
    s1_d.dr  = qdr[WIDTH-1:0];
    s1_d.di  = qdi[WIDTH-1:0];
  end

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  s1 <= '0;
    else if (en) s1 <= s1_d;
  end

  logic signed [S2W-1:0] xar, xai, xbr, xbi;
  logic signed [S2W-1:0] xcr, xci, xdr, xdi;
  assign xar = S2W'($signed(s1.ar));
  assign xai = S2W'($signed(s1.ai));
  assign xbr = S2W'($signed(s1.br));
  assign xbi = S2W'($signed(s1.bi));
  assign xcr = S2W'($signed(s1.cr));
  assign xci = S2W'($signed(s1.ci));
  assign xdr = S2W'($signed(s1.dr));
  assign xdi = S2W'($signed(s1.di));

  // S2 next value: radix-4 sums with 2 guard bits
  always_comb begin
    s2_d     = '0;
    s2_d.v   = s1.v;
    s2_d.sh  = s1.sh;
    s2_d.sat = s1.sat;
    s2_d.y0r = xar + xbr + xcr + xdr;
    s2_d.y0i = xai + xbi + xci + xdi;
    s2_d.y1r = xar + xbi - xcr - xdi;
    s2_d.y1i = xai - xbr - xci + xdr;
    s2_d.y2r = xar - xbr + xcr - xdr;
    s2_d.y2i = xai - xbi + xci - xdi;
    s2_d.y3r = xar - xbi - xcr + xdi;
    s2_d.y3i = xai + xbr - xci - xdr;
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  s2 <= '0;
    else if (en) s2 <= s2_d;
  end

  logic [WIDTH:0] q0r, q0i, q1r, q1i, q2r, q2i, q3r, q3i;
  assign q0r = sc_q(s2.y0r, s2.sh);
  assign q0i = sc_q(s2.y0i, s2.sh);
  assign q1r = sc_q(s2.y1r, s2.sh);
  assign q1i = sc_q(s2.y1i, s2.sh);
  assign q2r = sc_q(s2.y2r, s2.sh);
  assign q2i = sc_q(s2.y2i, s2.sh);
  assign q3r = sc_q(s2.y3r, s2.sh);
  assign q3i = sc_q(s2.y3i, s2.sh);

  logic s3_sat;
  assign s3_sat = q0r[WIDTH] | q0i[WIDTH] |
                  q1r[WIDTH] | q1i[WIDTH] |
                  q2r[WIDTH] | q2i[WIDTH] |
                  q3r[WIDTH] | q3i[WIDTH];

  // S3 output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      y0r <= '0;
      y0i <= '0;
      y1r <= '0;
      y1i <= '0;
      y2r <= '0;
      y2i <= '0;
      y3r <= '0;
      y3i <= '0;
    end else if (en) begin
      out_valid <= s2.v;
      out_sat   <= s2.v & (s2.sat | s3_sat);
      y0r <= q0r[WIDTH-1:0];
      y0i <= q0i[WIDTH-1:0];
      y1r <= q1r[WIDTH-1:0];
      y1i <= q1i[WIDTH-1:0];
      y2r <= q2r[WIDTH-1:0];
      y2i <= q2i[WIDTH-1:0];
      y3r <= q3r[WIDTH-1:0];
      y3i <= q3i[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_radix4_bfly_pipe.sv
// Directed bench for radix4_bfly_pipe:
// vector table, backpressure and async reset.
module tb_radix4_bfly_pipe;

  localparam int ONE  = 32767;
  localparam int MONE = -32768;
  localparam int NV   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [15:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic signed [15:0] cr = '0, ci = '0, dr = '0, di = '0;
  logic signed [15:0] w1r = '0, w1i = '0, w2r = '0;
  logic signed [15:0] w2i = '0, w3r = '0, w3i = '0;
  logic [1:0] shift = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [15:0] y0r, y0i, y1r, y1i;
  logic signed [15:0] y2r, y2i, y3r, y3i;
  logic out_sat;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    int a[8];
    int w[6];
    int sh;
    int e[8];
    int sat;
  } vec_t;

  vec_t tbl[NV];
  vec_t bp[6];

  always #5 clk = ~clk;

  radix4_bfly_pipe #(.WIDTH(16), .TW_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .cr(cr), .ci(ci), .dr(dr), .di(di),
    .w1r(w1r), .w1i(w1i), .w2r(w2r),
    .w2i(w2i), .w3r(w3r), .w3i(w3i),
    .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0r(y0r), .y0i(y0i), .y1r(y1r), .y1i(y1i),
    .y2r(y2r), .y2i(y2i), .y3r(y3r), .y3i(y3i),
    .out_sat(out_sat)
  );

  function automatic vec_t mk(
    input int a0, a1, a2, a3, a4, a5, a6, a7,
    input int t0, t1, t2, t3, t4, t5,
    input int sh,
    input int e0, e1, e2, e3, e4, e5, e6, e7,
    input int sat
  );
    vec_t v;
    v.a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    v.w = '{t0, t1, t2, t3, t4, t5};
    v.sh = sh;
    v.e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    v.sat = sat;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ar = 16'(v.a[0]); ai = 16'(v.a[1]);
    br = 16'(v.a[2]); bi = 16'(v.a[3]);
    cr = 16'(v.a[4]); ci = 16'(v.a[5]);
    dr = 16'(v.a[6]); di = 16'(v.a[7]);
    w1r = 16'(v.w[0]); w1i = 16'(v.w[1]);
    w2r = 16'(v.w[2]); w2i = 16'(v.w[3]);
    w3r = 16'(v.w[4]); w3i = 16'(v.w[5]);
    shift = 2'(v.sh);
  endtask

  task automatic cmp_vec(input string tag, input vec_t v);
    chk({tag, " y0r"}, int'(y0r), v.e[0]);
    chk({tag, " y0i"}, int'(y0i), v.e[1]);
    chk({tag, " y1r"}, int'(y1r), v.e[2]);
    chk({tag, " y1i"}, int'(y1i), v.e[3]);
    chk({tag, " y2r"}, int'(y2r), v.e[4]);
    chk({tag, " y2i"}, int'(y2i), v.e[5]);
    chk({tag, " y3r"}, int'(y3r), v.e[6]);
    chk({tag, " y3i"}, int'(y3i), v.e[7]);
    chk({tag, " out_sat"}, int'(out_sat), v.sat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, sent, recv, extra;
    logic stall;

    // 0x7FFF is just under 1, so x*W rounds 30000 to 29999
    // and -30000 to -29999; that leaks into y1/y2/y3.
    tbl[0] = mk(1000,0, 1000,0, 1000,0, 1000,0,
                ONE,0, ONE,0, ONE,0, 2,
                1000,0, 0,0, 0,0, 0,0, 0);
    tbl[1] = mk(0,0, 1000,0, 0,0, 0,0,
                0,MONE, ONE,0, ONE,0, 0,
                0,-1000, -1000,0, 0,1000, 1000,0, 0);
    tbl[2] = mk(30000,0, 30000,0, 30000,0, 30000,0,
                ONE,0, ONE,0, ONE,0, 0,
                32767,0, 1,0, 1,0, 1,0, 1);
    tbl[3] = mk(0,0, -32768,0, 0,0, 0,0,
                MONE,0, 0,0, 0,0, 0,
                32767,0, 0,-32767, -32767,0, 0,32767, 1);
    tbl[4] = mk(100,-50, 0,0, 0,0, 0,0,
                ONE,0, ONE,0, ONE,0, 1,
                50,-25, 50,-25, 50,-25, 50,-25, 0);
    tbl[5] = mk(7,-7, 0,0, 0,0, 0,0,
                ONE,0, ONE,0, ONE,0, 3,
                2,-2, 2,-2, 2,-2, 2,-2, 0);
    tbl[6] = mk(-30000,0, -30000,0, -30000,0, -30000,0,
                ONE,0, ONE,0, ONE,0, 0,
                -32768,0, -1,0, -1,0, -1,0, 1);
    tbl[7] = mk(0,0, 1000,2000, 0,0, 0,0,
                16384,16384, ONE,0, ONE,0, 0,
                -500,1500, 1500,500, 500,-1500, -1500,-500, 0);
    tbl[8] = mk(10,20, 0,0, 300,-100, 0,0,
                ONE,0, 0,ONE, ONE,0, 0,
                110,320, -90,-280, 110,320, -90,-280, 0);
    tbl[9] = mk(0,0, 0,0, 0,0, 200,0,
                ONE,0, ONE,0, MONE,0, 0,
                -200,0, 0,-200, 200,0, 0,200, 0);
    for (int k = 0; k < 6; k++) begin
      int re, im;
      re = 100 * (k + 1);
      im = -3 * (k + 1);
      bp[k] = mk(re,im, 0,0, 0,0, 0,0,
                 ONE,0, ONE,0, ONE,0, 0,
                 re,im, re,im, re,im, re,im, 0);
    end

    // reset state
    #3;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst y0r", int'(y0r), 0);
    chk("rst out_sat", int'(out_sat), 0);
    chk("rst in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", int'(in_ready), 1);
    chk("post-rst out_valid", int'(out_valid), 0);

    // table vectors, one at a time
    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      @(negedge clk);
      drive(tbl[i]);
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk({tag, " latency"}, lat, 3);
      cmp_vec(tag, tbl[i]);
    end

    // back-to-back stream with 4 stalled cycles
    @(negedge clk);
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 8);
      if (sent < 6) begin
        drive(bp[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      stall = out_valid && !out_ready;
      chk($sformatf("bp c%0d in_ready", cyc),
          int'(in_ready), int'(!stall));
      if (out_valid) begin
        cmp_vec($sformatf("bp%0d c%0d", recv, cyc), bp[recv]);
        if (out_ready) recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp received", recv, 6);
    in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    chk("bp extra outputs", extra, 0);

    // async reset with three vectors in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(tbl[2]);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("inflight out_valid", int'(out_valid), 1);
    chk("inflight y0r", int'(y0r), 32767);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async y0r", int'(y0r), 0);
    chk("async y2r", int'(y2r), 0);
    chk("async out_sat", int'(out_sat), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel in_ready", int'(in_ready), 1);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    chk("stale outputs", extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
